// File: rtl/lsu_bus_master.sv
// Load/store initiator for the data-memory req/gnt bus: registers one access,
// holds req until gnt or timeout, and returns sign-extended load data.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_valid_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_busy_o,
  output logic        lsu_done_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_misalign_o,
  output logic        lsu_fault_o,
  output logic        req_o,
  output logic        ce_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic        we_o,
  output logic [1:0]  hb_o,
  output logic        uload_o,
  input  logic        gnt_i,
  input  logic [31:0] rdata_i
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    REQ  = 3'b010,
    RESP = 3'b100
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic             done_q, done_d;
  logic             mis_q, mis_d;
  logic             fault_q, fault_d;
  logic             uload_q, uload_d;
  logic [1:0]       hb_q, hb_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic             illegal;
  logic             misal;
  logic [1:0]       hb_dec;
  logic [DW-1:0]    load_ext;

  // Request decode: illegal encodings and alignment are judged on the raw inputs.
  always_comb begin
    illegal = (lsu_funct3_i == 3'b011) || (lsu_funct3_i == 3'b110) ||
              (lsu_funct3_i == 3'b111) || (lsu_we_i && lsu_funct3_i[2]);
    misal   = ((lsu_funct3_i[1:0] == 2'b10) && (lsu_addr_i[1:0] != 2'b00)) ||
              ((lsu_funct3_i[1:0] == 2'b01) && lsu_addr_i[0]);
    hb_dec  = (lsu_funct3_i[1:0] == 2'b11) ? HB_WORD : lsu_funct3_i[1:0];
  end

  // Slave data is already lane-extracted and zero-extended; only signed loads need work.
  always_comb begin
    load_ext = rdata_i;
    if (!uload_q && (hb_q == HB_BYTE)) begin
      load_ext = {{(DW-8){rdata_i[7]}}, rdata_i[7:0]};
    end else if (!uload_q && (hb_q == HB_HALF)) begin
      load_ext = {{(DW-16){rdata_i[15]}}, rdata_i[15:0]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
      uload_q <= 1'b0;
      hb_q    <= HB_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      fault_q <= fault_d;
      uload_q <= uload_d;
      hb_q    <= hb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    fault_d = 1'b0;
    uload_d = uload_q;
    hb_d    = hb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (lsu_valid_i) begin
          addr_d  = lsu_addr_i;
          wdata_d = lsu_wdata_i;
          we_d    = lsu_we_i;
          hb_d    = hb_dec;
          uload_d = lsu_we_i ? 1'b0 : lsu_funct3_i[2];
          if (illegal || misal) begin
            state_d = RESP;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
            req_d   = 1'b1;
          end
        end
      end
      REQ: begin
        // A grant in the final timeout cycle still completes normally.
        if (gnt_i) begin
          if (!we_q) begin
            rdata_d = load_ext;
          end
          state_d = RESP;
          req_d   = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          req_d   = 1'b0;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign lsu_busy_o     = (state_q != IDLE);
  assign lsu_done_o     = done_q;
  assign lsu_rdata_o    = rdata_q;
  assign lsu_misalign_o = mis_q;
  assign lsu_fault_o    = fault_q;
  assign req_o          = req_q;
  assign ce_o           = req_q;
  assign addr_o         = addr_q;
  assign wdata_o        = wdata_q;
  assign we_o           = we_q;
  assign hb_o           = hb_q;
  assign uload_o        = uload_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: word SRAM slave with programmable grant delay,
// byte-level architectural memory model, directed and random accesses.
module tb_lsu_bus_master;

  localparam int unsigned TOUT = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        lsu_valid_i, lsu_we_i;
  logic [2:0]  lsu_funct3_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_busy_o, lsu_done_o, lsu_misalign_o, lsu_fault_o;
  logic [31:0] lsu_rdata_o;
  logic        req_o, ce_o, we_o, uload_o, gnt_i;
  logic [31:0] addr_o, wdata_o, rdata_i;
  logic [1:0]  hb_o;

  int n_vec = 0;
  int n_err = 0;

  lsu_bus_master #(.TIMEOUT(TOUT), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lsu_valid_i(lsu_valid_i), .lsu_we_i(lsu_we_i), .lsu_funct3_i(lsu_funct3_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_busy_o(lsu_busy_o), .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_misalign_o(lsu_misalign_o), .lsu_fault_o(lsu_fault_o),
    .req_o(req_o), .ce_o(ce_o), .addr_o(addr_o), .wdata_o(wdata_o), .we_o(we_o),
    .hb_o(hb_o), .uload_o(uload_o), .gnt_i(gnt_i), .rdata_i(rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Slave: 16-word SRAM, grants in the gnt_delay-th req cycle (0 = never).
  logic [31:0] smem [16];
  logic [31:0] sword;
  int          gnt_delay = 3;
  logic        gnt_stray = 1'b0;
  int          scnt;

  assign sword = smem[addr_o[5:2]];
  always_comb begin
    gnt_i = (req_o && gnt_delay > 0 && scnt == gnt_delay - 1) || (gnt_stray && !req_o);
    if (hb_o == 2'b10)      rdata_i = sword;
    else if (hb_o == 2'b01) rdata_i = (sword >> (16 * addr_o[1])) & 32'h0000FFFF;
    else                    rdata_i = (sword >> (8 * addr_o[1:0])) & 32'h000000FF;
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scnt <= 0;
      for (int i = 0; i < 16; i++) smem[i] <= '0;
    end else begin
      scnt <= (req_o && !gnt_i) ? scnt + 1 : 0;
      if (req_o && gnt_i && we_o) begin
        if (hb_o == 2'b10) smem[addr_o[5:2]] <= wdata_o;
        else if (hb_o == 2'b01) smem[addr_o[5:2]][16*addr_o[1] +: 16] <= wdata_o[15:0];
        else smem[addr_o[5:2]][8*addr_o[1:0] +: 8] <= wdata_o[7:0];
      end
    end
  end

  // Architectural reference: byte-addressed memory plus the last load result.
  logic [7:0]  rmem [64];
  logic [31:0] last_rd;

  task automatic ref_clear();
    for (int i = 0; i < 64; i++) rmem[i] = 8'h00;
    last_rd = 32'h0;
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input int a, input logic [31:0] d);
    for (int i = 0; i < size_bytes(f3); i++) rmem[a + i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
    logic [31:0] v;
    int n;
    n = size_bytes(f3);
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rmem[a + i];
    if (!f3[2] && n < 4 && v[8*n-1]) begin
      for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One access: predict outcome, drive valid for one cycle, watch bus until done.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int delay, input logic stray);
    logic illegal, mis, fault, held;
    int exp_n, nreq, done_k;
    logic mis_o, fault_o;
    logic [31:0] rd_o;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
    mis = illegal || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00) || (f3[1:0] == 2'b01 && addr[0]);
    fault = !mis && (delay == 0 || delay > int'(TOUT));
    exp_n = mis ? 0 : fault ? int'(TOUT) : delay;
    if (!mis && !fault) begin
      if (we) ref_store(f3, int'(addr), wd);
      else last_rd = ref_load(f3, int'(addr));
    end
    gnt_delay = delay;
    gnt_stray = stray;
    @(negedge clk_i);
    lsu_valid_i = 1'b1; lsu_we_i = we; lsu_funct3_i = f3; lsu_addr_i = addr; lsu_wdata_i = wd;
    @(negedge clk_i);
    lsu_valid_i = 1'b0; lsu_we_i = ~we; lsu_funct3_i = 3'($urandom);
    lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
    nreq = 0; done_k = 0; held = 1'b1; mis_o = 1'bx; fault_o = 1'bx; rd_o = 'x;
    for (int k = 1; k <= 20; k++) begin
      if (req_o) begin
        nreq++;
        if (ce_o !== 1'b1 || addr_o !== addr || wdata_o !== wd || we_o !== we ||
            hb_o !== f3[1:0] || uload_o !== (we ? 1'b0 : f3[2])) held = 1'b0;
      end
      if (lsu_done_o) begin
        done_k = k; mis_o = lsu_misalign_o; fault_o = lsu_fault_o; rd_o = lsu_rdata_o;
        break;
      end
      @(negedge clk_i);
    end
    check("req_cycles", 32'(nreq), 32'(exp_n));
    check("done_latency", 32'(done_k), 32'(exp_n + 1));
    if (exp_n > 0) check("bus_held", 32'(held), 32'd1);
    check("misalign", 32'(mis_o), 32'(mis));
    check("fault", 32'(fault_o), 32'(fault));
    check("rdata", rd_o, last_rd);
    @(negedge clk_i);
    check("done_pulse_end", {30'd0, lsu_done_o, lsu_busy_o}, 32'd0);
  endtask

  initial begin
    int ndone, rises, drop_at;
    int dk [3];
    logic prev_req;

    rst_ni = 1'b0; lsu_valid_i = 1'b0; lsu_we_i = 1'b0; lsu_funct3_i = 3'd0;
    lsu_addr_i = '0; lsu_wdata_i = '0;
    ref_clear();
    repeat (3) @(negedge clk_i);
    check("rst_ctrl", {26'd0, req_o, ce_o, we_o, lsu_done_o, lsu_misalign_o, lsu_fault_o}, 32'd0);
    check("rst_bus", {addr_o ^ wdata_o ^ lsu_rdata_o}, 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_misc", {28'd0, hb_o, uload_o, lsu_busy_o}, {28'd0, 2'b10, 1'b0, 1'b0});
    rst_ni = 1'b1;

    // Directed: word store/load, signed/unsigned byte and half loads.
    run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 1'b0);
    run_op(1'b0, 3'b010, 32'h10, 32'h0, 3, 1'b0);
    check("lw_const", lsu_rdata_o, 32'hDEADBEEF);
    run_op(1'b1, 3'b010, 32'h20, 32'h000000F0, 3, 1'b0);
    run_op(1'b0, 3'b000, 32'h20, 32'h0, 3, 1'b0);
    check("lb_const", lsu_rdata_o, 32'hFFFFFFF0);
    run_op(1'b0, 3'b100, 32'h20, 32'h0, 3, 1'b0);
    check("lbu_const", lsu_rdata_o, 32'h000000F0);
    run_op(1'b1, 3'b010, 32'h24, 32'h00008001, 2, 1'b0);
    run_op(1'b0, 3'b001, 32'h24, 32'h0, 1, 1'b0);
    check("lh_const", lsu_rdata_o, 32'hFFFF8001);
    run_op(1'b0, 3'b101, 32'h24, 32'h0, 3, 1'b0);
    check("lhu_const", lsu_rdata_o, 32'h00008001);

    // Misaligned accesses, timeout, grant in the last timeout cycle, stray grants.
    run_op(1'b0, 3'b010, 32'h12, 32'h0, 3, 1'b1);
    run_op(1'b1, 3'b001, 32'h13, 32'h1234, 3, 1'b0);
    run_op(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0);
    run_op(1'b1, 3'b010, 32'h10, 32'h5A5A0FF0, 0, 1'b0);
    run_op(1'b0, 3'b010, 32'h10, 32'h0, int'(TOUT), 1'b1);

    // Back-to-back: valid held across three loads.
    gnt_delay = 3; gnt_stray = 1'b0;
    @(negedge clk_i);
    lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_funct3_i = 3'b010; lsu_addr_i = 32'h10;
    last_rd = ref_load(3'b010, 16);
    ndone = 0; rises = 0; drop_at = -1; prev_req = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (req_o && !prev_req) rises++;
      prev_req = req_o;
      if (lsu_done_o) begin
        if (ndone < 3) dk[ndone] = c;
        ndone++;
        if (ndone == 2) drop_at = c + 2;
      end
      if (c == drop_at) lsu_valid_i = 1'b0;
    end
    check("b2b_done_count", 32'(ndone), 32'd3);
    check("b2b_req_bursts", 32'(rises), 32'd3);
    check("b2b_spacing", 32'(dk[1] - dk[0]), 32'd5);
    check("b2b_rdata", lsu_rdata_o, last_rd);

    // Reset asserted during REQ.
    run_op(1'b0, 3'b010, 32'h8, 32'h0, 0, 1'b0);
    gnt_delay = 0;
    @(negedge clk_i);
    lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_funct3_i = 3'b010; lsu_addr_i = 32'h8;
    @(negedge clk_i);
    lsu_valid_i = 1'b0;
    @(negedge clk_i);
    check("pre_rst_req", 32'(req_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1 check("rst_mid_req", {29'd0, req_o, ce_o, lsu_busy_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    ref_clear();
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (lsu_done_o) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);
    check("rst_rdata", lsu_rdata_o, 32'd0);

    // Random accesses against the reference model.
    for (int n = 0; n < 40; n++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
      run_op(1'($urandom), 3'($urandom), 32'($urandom_range(0, 63)), $urandom, d,
             1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Core-side load/store initiator that drives the data-memory req/gnt bus toward the word-addressed SRAM slave.
- Accepts one RISC-V load/store per transaction from the execute stage and registers all bus signals.
- Holds req until gnt, sign-extends load data, and reports done, misalign and timeout back to the pipeline.
- Sits between the execute/memory pipeline stage and the data bus.

Parameters:
- TIMEOUT, 255, number of REQ cycles without gnt before the transaction is aborted with fault (range 1..255).
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- lsu_valid_i  in  1  request from pipeline; sampled only in IDLE
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_funct3_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- lsu_addr_i  in  32  byte address
- lsu_wdata_i  in  32  store data, right-aligned
- lsu_busy_o  out  1  state != IDLE
- lsu_done_o  out  1  one-cycle completion pulse
- lsu_rdata_o  out  32  load result, valid while done_o = 1
- lsu_misalign_o  out  1  one-cycle pulse with done_o; address misaligned or funct3 illegal
- lsu_fault_o  out  1  one-cycle pulse with done_o; timeout occurred
- req_o  out  1  bus request
- ce_o  out  1  chip enable, equal to req_o
- addr_o  out  32  registered byte address
- wdata_o  out  32  registered store data, unshifted
- we_o  out  1  registered write enable
- hb_o  out  2  size: 10 word, 01 half, 00 byte
- uload_o  out  1  funct3[2] for loads, 0 for stores
- gnt_i  in  1  bus grant; rdata_i valid in the same cycle
- rdata_i  in  32  slave data, lane-extracted and zero-extended

Behaviour:
- Reset, asynchronous: state = IDLE, counter = 0.
- Reset values of outputs: req_o, ce_o, we_o, done_o, misalign_o and fault_o are 0; addr_o, wdata_o and lsu_rdata_o are 0; hb_o = 10; uload_o = 0.
- Reset asserted mid-transaction drops req_o immediately and produces no done pulse.
- FSM is one-hot with states IDLE, REQ, RESP.

IDLE:
- If lsu_valid_i is 1, register addr, wdata, we, hb and uload, and decode funct3 to hb.
- Illegal funct3 is 011, 110 or 111, or any store with funct3[2] = 1.
- Misalign is W with addr[1:0] != 0, or H with addr[0] = 1.
- On illegal funct3 or misalign, go to RESP with misalign flagged; req_o is never raised.
- Otherwise go to REQ and clear the counter.

REQ:
- req_o = ce_o = 1; all bus outputs are held stable.
- On gnt_i = 1: capture the load result and go to RESP.
  - B: sign-extend rdata_i[7].
  - H: sign-extend rdata_i[15].
  - BU, HU and W: rdata_i passes through unchanged.
  - Stores leave lsu_rdata_o unchanged.
- Without gnt_i, the counter increments. When the counter equals TIMEOUT-1 and gnt_i = 0, go to RESP with fault flagged and req_o dropped.
- A gnt_i arriving in the same cycle as the timeout wins: normal completion, no fault.

RESP:
- req_o = 0 for the full cycle; this guarantees the slave returns to idle before any new request.
- done_o = 1, with misalign_o or fault_o as flagged; go to IDLE.
- lsu_valid_i is ignored while busy; the pipeline stalls on lsu_busy_o.

Timing and back-to-back:
- Latency against the 3-state SRAM: valid sampled at edge T, req_o high in cycles T+1..T+3, gnt in T+3, done_o in T+4.
- Minimum request spacing is therefore 5 cycles. valid held in the done cycle is accepted at the next IDLE edge.
- gnt_i outside REQ is ignored.

Test Plan:
- Store word: valid, we=1, funct3=010, addr 0x10, wdata 0xDEADBEEF -> req_o high for 3 cycles with hb_o=10; done_o at T+4; a following LW at 0x10 returns 0xDEADBEEF.
- Byte loads: slave rdata_i = 0x000000F0; LB -> lsu_rdata_o = 0xFFFFFFF0; LBU -> 0x000000F0. With rdata_i = 0x00008001: LH -> 0xFFFF8001, LHU -> 0x00008001.
- Misalign: LW at 0x12, then SH at 0x13 -> req_o never asserted; done_o with misalign_o = 1 at T+1 for each.
- Timeout: TIMEOUT=4, gnt_i tied 0 -> req_o high exactly 4 cycles, then done_o with fault_o = 1; gnt_i pulsed in the 4th REQ cycle -> normal done, fault_o = 0.
- Back-to-back and reset: valid held high across 3 loads -> req_o is low for at least 1 cycle between transactions and exactly 3 done pulses occur. rst_ni pulled low during REQ -> req_o = 0 and busy_o = 0 immediately, no done pulse.
